debounce_edge_detect: RTL and testbench
=======================================

# debounce_edge_detect

Upstream conditioning stage for the asynchronous-reset D flip-flop data path. It takes a raw, asynchronous, possibly bouncing level (switch or external pin), synchronises it into the `clk` domain and filters it with a stability counter. It then produces a clean debounced level plus single-cycle edge pulses. The debounced level `d_out` is the signal that drives the downstream registered `d_in` of the FSMD data path.

## Interface
- `STABLE_CNT`, default 4: consecutive in-window cycles a new level must hold before it is accepted; legal range 1..1023.
- `clk`, input, 1: single rising-edge clock.
- `reset_n`, input, 1: reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `d_in`, input, 1: raw asynchronous level.
- `d_out`, output, 1: debounced, registered level.
- `rise_pulse`, output, 1: one-cycle pulse on an accepted 0→1 transition.
- `fall_pulse`, output, 1: one-cycle pulse on an accepted 1→0 transition (see Configuration).

## Operation
- **Synchroniser.** Two flops, `s1 <= d_in`, `s2 <= s1`, both reset to 0. Only `s2` is used by the logic below.
- **FSM states:** `IDLE_LOW`, `WAIT_HIGH`, `IDLE_HIGH`, `WAIT_LOW`. The reset state is `IDLE_LOW`.
- **`IDLE_LOW`:**
  - If `s2`=1, go to `WAIT_HIGH` with `cnt`=0.
  - Otherwise stay.
- **`WAIT_HIGH`:**
  - If `s2`=0, return to `IDLE_LOW` with `cnt`=0. No pulse.
  - Else if `cnt`==`STABLE_CNT`-1, go to `IDLE_HIGH`, set `d_out`=1 and `rise_pulse`=1.
  - Else `cnt`++.
- **`IDLE_HIGH` / `WAIT_LOW`:** mirror image of the above. Acceptance clears `d_out` and asserts `fall_pulse`.
- **Counter.** `cnt` is `$clog2(STABLE_CNT+1)` bits wide. It is cleared on every entry to a WAIT state. It never wraps, because the compare-before-increment guarantees that.
- **Outputs.** All outputs are registered; there is no combinational path from `d_in` to any output.
- **Pulse width.** `rise_pulse` and `fall_pulse` are high for exactly one cycle. They are never both high. They are never high in consecutive cycles, because a WAIT state always intervenes.
- **Glitch rejection.** Any `s2` excursion shorter than `STABLE_CNT`+1 samples leaves `d_out` and both pulses unchanged.
- **Reset mid-operation.** Asserting `reset_n` low immediately forces the following, regardless of clock: `s1`, `s2`, `cnt` = 0, state = `IDLE_LOW`, `d_out` = 0, both pulses = 0.
  - If `d_in` is held high across reset release, it is treated as a fresh rising edge. `rise_pulse` then fires after the normal latency.
- **Reset values.** `d_out`=0, `rise_pulse`=0, `fall_pulse`=0.

## Timing
- Let edge k be the first rising clock edge at which `s1` samples the new `d_in` level.
- `s2` changes at edge k+1, and the FSM enters the WAIT state at edge k+2.
- `d_out` and the pulse update at edge k+2+`STABLE_CNT`, provided `d_in` holds through that point. With the default `STABLE_CNT`=4 this is edge k+6.
- Minimum accepted level duration is `STABLE_CNT`+1 consecutive `s2` samples.
- Minimum `d_out` period is 2·(`STABLE_CNT`+1) cycles.

## Configuration
- Feature macro: `DEBOUNCE_FALL_PULSE_EN`.
- **Defined:** the falling-edge pulse logic is compiled in, and `fall_pulse` behaves as in Operation.
- **Undefined:** the falling-edge pulse logic is compiled out, and `fall_pulse` is tied to constant 0.
  - The port list is unchanged in both builds.
  - `d_out` still falls normally.

## Structure
- **Shared package `debounce_pkg`** holds:
  - the `state_t` enum (2-bit encoding: `IDLE_LOW`=0, `WAIT_HIGH`=1, `IDLE_HIGH`=2, `WAIT_LOW`=3);
  - `STABLE_CNT_MAX`=1023;
  - the function computing the counter width.
- **Sub-module `sync_2ff`:** parameterless two-flop synchroniser with ports `clk`, `reset_n`, `d_in`, `d_out`, asynchronous active-low reset to 0. It is instantiated once.
- **Top level** contains the FSM, counter and output registers.

## Test plan
- **Clean rise:** reset, release, then `d_in` 0→1 sampled at edge k, with `STABLE_CNT`=4 → `d_out`=1 and `rise_pulse`=1 for exactly one cycle at edge k+6; `fall_pulse`=0 throughout.
- **Bounce rejection:** `d_in` high for 3 cycles, low for 2, high for 4, then low → `d_out` stays 0 and no pulses occur. Then `d_in` high for 5+ cycles → a single `rise_pulse` fires.
- **Clean fall:** with `d_out`=1, `d_in` 1→0 sampled at edge k → `d_out`=0 at edge k+6.
  - With `DEBOUNCE_FALL_PULSE_EN` defined: `fall_pulse` is high for one cycle at edge k+6.
  - Without it: `fall_pulse` stays 0.
- **Mid-wait reset:** `d_in` high, `reset_n` pulled low asynchronously between clock edges while in `WAIT_HIGH` with `cnt`=2 → all outputs are 0 immediately. After release with `d_in` still high, `rise_pulse` fires at release-sampling edge +6.
- **Boundary `STABLE_CNT`=1:** `d_in` high for exactly 2 sampled cycles → accepted at edge k+3. `d_in` high for 1 sampled cycle → rejected.
- **Pulse exclusivity:** random `d_in` toggling for 10,000 cycles (checked by assertion) → `rise_pulse` and `fall_pulse` are never high together, never high in two consecutive cycles, and each accepted transition coincides with a `d_out` change.

Source files
------------

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared state encoding, parameter limit and counter sizing for debounce_edge_detect
package debounce_pkg;
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;
  localparam int STABLE_CNT_MAX = 1023;
  function automatic int cnt_width(input int stable_cnt);
    return $clog2(stable_cnt + 1);
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous level, async active-low reset to 0
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d_in,
  output logic d_out
);
  logic s1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {d_out, s1} <= 2'b00;
    else {d_out, s1} <= {s1, d_in};
endmodule

// File: rtl/debounce_edge_detect.sv
// debounce_edge_detect: synchronise, debounce and edge-detect a raw level; DEBOUNCE_FALL_PULSE_EN enables fall_pulse
module debounce_edge_detect
  import debounce_pkg::*;
#(
  parameter int STABLE_CNT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_in,
  output logic d_out,
  output logic rise_pulse,
  output logic fall_pulse
);
  localparam int CW = cnt_width(STABLE_CNT);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CNT - 1);
  logic s2;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic d_out_nx, rise_nx;
  sync_2ff u_sync (.clk(clk), .reset_n(reset_n), .d_in(d_in), .d_out(s2));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state      <= IDLE_LOW;
      cnt        <= '0;
      d_out      <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      d_out      <= d_out_nx;
      rise_pulse <= rise_nx;
    end
  // compare before increment, so cnt never exceeds STABLE_CNT-1
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    d_out_nx = d_out;
    rise_nx  = 1'b0;
    case (state)
      IDLE_LOW:
        if (s2) begin
          state_nx = WAIT_HIGH;
          cnt_nx   = '0;
        end
      WAIT_HIGH:
        if (!s2) begin
          state_nx = IDLE_LOW;
          cnt_nx   = '0;
        end else if (cnt == LAST) begin
          state_nx = IDLE_HIGH;
          d_out_nx = 1'b1;
          rise_nx  = 1'b1;
        end else cnt_nx = cnt + 1'b1;
      IDLE_HIGH:
        if (!s2) begin
          state_nx = WAIT_LOW;
          cnt_nx   = '0;
        end
      WAIT_LOW:
        if (s2) begin
          state_nx = IDLE_HIGH;
          cnt_nx   = '0;
        end else if (cnt == LAST) begin
          state_nx = IDLE_LOW;
          d_out_nx = 1'b0;
        end else cnt_nx = cnt + 1'b1;
      default: ;
    endcase
  end
`ifdef DEBOUNCE_FALL_PULSE_EN
  logic fall_nx;
  assign fall_nx = state == WAIT_LOW && !s2 && cnt == LAST;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) fall_pulse <= 1'b0;
    else fall_pulse <= fall_nx;
`else
  assign fall_pulse = 1'b0;
`endif
endmodule

// File: tb/tb_debounce_edge_detect.sv
// tb_debounce_edge_detect: scoreboard bench for debounce_edge_detect with STABLE_CNT=4 and STABLE_CNT=1 instances
module tb_debounce_edge_detect;
`ifdef DEBOUNCE_FALL_PULSE_EN
  localparam logic FE = 1'b1;
`else
  localparam logic FE = 1'b0;
`endif
  typedef struct {
    int   cyc;
    logic d;
    logic r;
    logic f;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic d_in = 1'b0, d1_in = 1'b0;
  logic d_out, rise_pulse, fall_pulse;
  logic d1_out, rise1, fall1;
  int cyc = 0, n_cmp = 0, n_bad = 0, k;
  bit sb_en = 1'b1, h4, h1;
  exp_t q4[$], q1[$];
  exp_t e4, e1;
  logic pd4 = 1'b0, pd1 = 1'b0;
  logic pr4 = 1'b0, pf4 = 1'b0, pr1 = 1'b0, pf1 = 1'b0;
  debounce_edge_detect #(.STABLE_CNT(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .d_in(d_in),
    .d_out(d_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse)
  );
  debounce_edge_detect #(.STABLE_CNT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .d_in(d1_in),
    .d_out(d1_out), .rise_pulse(rise1), .fall_pulse(fall1)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, required %b (cyc %0d)", nm, got, exp, cyc);
    end
  endtask
  task automatic cmp_evt(input string nm, input bit have, input exp_t e, input logic d, input logic r, input logic f);
    n_cmp++;
    if (!have) begin
      n_bad++;
      $display("FAIL %s unexpected event: cyc=%0d d_out=%b rise=%b fall=%b, required no event", nm, cyc, d, r, f);
    end else if (e.cyc != cyc || e.d !== d || e.r !== r || e.f !== f) begin
      n_bad++;
      $display("FAIL %s event: got cyc=%0d d_out=%b rise=%b fall=%b, required cyc=%0d d_out=%b rise=%b fall=%b",
               nm, cyc, d, r, f, e.cyc, e.d, e.r, e.f);
    end
  endtask
  task automatic push(input int ch, input int c, input logic d, input logic r, input logic f);
    exp_t e;
    e = '{cyc: c, d: d, r: r, f: f};
    if (ch == 0) q4.push_back(e);
    else q1.push_back(e);
  endtask
  // called at posedge+1; first posedge afterwards samples v
  task automatic hold(input int ch, input logic v, input int n);
    if (ch == 0) d_in = v;
    else d1_in = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  always @(negedge clk) begin
    if (reset_n && sb_en) begin
      if (d_out !== pd4 || rise_pulse || fall_pulse) begin
        h4 = q4.size() != 0;
        if (h4) e4 = q4.pop_front();
        cmp_evt("dut4", h4, e4, d_out, rise_pulse, fall_pulse);
      end
      if (d1_out !== pd1 || rise1 || fall1) begin
        h1 = q1.size() != 0;
        if (h1) e1 = q1.pop_front();
        cmp_evt("dut1", h1, e1, d1_out, rise1, fall1);
      end
    end
    pd4 = d_out;
    pd1 = d1_out;
  end
  always @(negedge clk) begin
    if (reset_n) begin
      a_excl4: assert (!(rise_pulse && fall_pulse)) else begin n_bad++; $error("FAIL excl4 rise and fall together"); end
      a_excl1: assert (!(rise1 && fall1)) else begin n_bad++; $error("FAIL excl1 rise and fall together"); end
      a_cons4: assert (!((rise_pulse || fall_pulse) && (pr4 || pf4))) else begin n_bad++; $error("FAIL cons4 pulses in consecutive cycles"); end
      a_cons1: assert (!((rise1 || fall1) && (pr1 || pf1))) else begin n_bad++; $error("FAIL cons1 pulses in consecutive cycles"); end
      a_rise4: assert (rise_pulse == (d_out && !pd4)) else begin n_bad++; $error("FAIL rise4 pulse/d_out mismatch"); end
      a_rise1: assert (rise1 == (d1_out && !pd1)) else begin n_bad++; $error("FAIL rise1 pulse/d_out mismatch"); end
      a_fall4: assert (!fall_pulse || (!d_out && pd4)) else begin n_bad++; $error("FAIL fall4 pulse without d_out fall"); end
      a_fall1: assert (!fall1 || (!d1_out && pd1)) else begin n_bad++; $error("FAIL fall1 pulse without d_out fall"); end
    end
    {pr4, pf4, pr1, pf1} = reset_n ? {rise_pulse, fall_pulse, rise1, fall1} : 4'b0;
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset d_out", d_out, 1'b0);
    chk("reset rise_pulse", rise_pulse, 1'b0);
    chk("reset fall_pulse", fall_pulse, 1'b0);
    reset_n = 1'b1;
    hold(0, 0, 3);
    k = cyc + 1;
    push(0, k + 6, 1'b1, 1'b1, 1'b0);
    hold(0, 1, 10);
    k = cyc + 1;
    push(0, k + 6, 1'b0, 1'b0, FE);
    hold(0, 0, 10);
    hold(0, 1, 3);
    hold(0, 0, 2);
    hold(0, 1, 4);
    hold(0, 0, 8);
    chk("bounce d_out", d_out, 1'b0);
    k = cyc + 1;
    push(0, k + 6, 1'b1, 1'b1, 1'b0);
    hold(0, 1, 5);
    k = cyc + 1;
    push(0, k + 6, 1'b0, 1'b0, FE);
    hold(0, 0, 10);
    hold(0, 1, 5);
    #2 reset_n = 1'b0;
    #1;
    chk("midwait d_out", d_out, 1'b0);
    chk("midwait rise_pulse", rise_pulse, 1'b0);
    chk("midwait fall_pulse", fall_pulse, 1'b0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    k = cyc + 1;
    push(0, k + 6, 1'b1, 1'b1, 1'b0);
    hold(0, 1, 10);
    chk("high before reset d_out", d_out, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("async reset d_out", d_out, 1'b0);
    d_in = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    hold(0, 0, 10);
    hold(1, 1, 1);
    hold(1, 0, 8);
    chk("cnt1 reject d_out", d1_out, 1'b0);
    k = cyc + 1;
    push(1, k + 3, 1'b1, 1'b1, 1'b0);
    hold(1, 1, 2);
    k = cyc + 1;
    push(1, k + 3, 1'b0, 1'b0, FE);
    hold(1, 0, 8);
    n_cmp++;
    if (q4.size() != 0) begin
      n_bad++;
      $display("FAIL dut4 drain: %0d expected events never seen, required 0", q4.size());
    end
    n_cmp++;
    if (q1.size() != 0) begin
      n_bad++;
      $display("FAIL dut1 drain: %0d expected events never seen, required 0", q1.size());
    end
    sb_en = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 5) == 0) d_in = ~d_in;
      if ($urandom_range(0, 3) == 0) d1_in = ~d1_in;
      @(posedge clk);
      #1;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
